reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp_if.sv | 28 ++
 rtl/reg_file_mp.sv | 89 ++++++++
 tb/tb_reg_file_mp.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle for the dual-write, dual-read register file.
// The master drives writes and read addresses; the slave returns read data and the conflict flag.
interface reg_file_mp_if #(
   parameter int DW = 16,
   parameter int AW = 3
);
   logic          WE;
   logic [AW-1:0] RW;
   logic [DW-1:0] busW;
   logic          WE2;
   logic [AW-1:0] RW2;
   logic [DW-1:0] busW2;
   logic [AW-1:0] RA;
   logic [AW-1:0] RB;
   logic [DW-1:0] busA;
   logic [DW-1:0] busB;
   logic          wr_conflict;

   modport master (
      output WE, RW, busW, WE2, RW2, busW2, RA, RB,
      input  busA, busB, wr_conflict
   );

   modport slave (
      input  WE, RW, busW, WE2, RW2, busW2, RA, RB,
      output busA, busB, wr_conflict
   );
endinterface

// File: rtl/reg_file_mp.sv
// Register file with two write ports (port 1 wins on collision) and two read ports.
// Reads are combinational with optional forwarding, or registered write-first.
module reg_file_mp #(
   parameter int DW       = 16,
   parameter int AW       = 3,
   parameter int ZERO_R0  = 0,
   parameter int BYPASS   = 1,
   parameter int READ_REG = 0
) (
   input logic         clk,
   input logic         rst_n,
   reg_file_mp_if.slave bus
);
   localparam int NREG = 2 ** AW;

   logic [DW-1:0] memReg [NREG];
   logic          we0Eff;
   logic          we1Eff;
   logic          wrConflictNext;
   logic          wrConflictReg;

   // Writes aimed at a hard-wired zero register are dropped before they can collide.
   always_comb begin
      we0Eff = bus.WE  && !((ZERO_R0 != 0) && (bus.RW  == '0));
      we1Eff = bus.WE2 && !((ZERO_R0 != 0) && (bus.RW2 == '0));
      wrConflictNext = we0Eff && we1Eff && (bus.RW == bus.RW2);
   end

   // Port 1 is assigned last so it takes the register on a same-address write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            memReg[i] <= '0;
         end
         wrConflictReg <= 1'b0;
      end else begin
         if (we0Eff) begin
            memReg[bus.RW] <= bus.busW;
         end
         if (we1Eff) begin
            memReg[bus.RW2] <= bus.busW2;
         end
         wrConflictReg <= wrConflictNext;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_read
      logic [AW-1:0] readAddr;
      logic [DW-1:0] storedVal;
      logic [DW-1:0] fwdVal;
      logic [DW-1:0] liveVal;
      logic [DW-1:0] readReg;
      logic [DW-1:0] readOut;

      assign readAddr = (gi == 0) ? bus.RA : bus.RB;

      always_comb begin
         storedVal = memReg[readAddr];
         fwdVal    = storedVal;
         if (we0Eff && (bus.RW == readAddr)) begin
            fwdVal = bus.busW;
         end
         if (we1Eff && (bus.RW2 == readAddr)) begin
            fwdVal = bus.busW2;
         end
         if ((ZERO_R0 != 0) && (readAddr == '0)) begin
            storedVal = '0;
            fwdVal    = '0;
         end
      end

      assign liveVal = (BYPASS != 0) ? fwdVal : storedVal;

      // The registered path always captures the write-first value.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            readReg <= '0;
         end else begin
            readReg <= fwdVal;
         end
      end

      assign readOut = (READ_REG != 0) ? readReg : (rst_n ? liveVal : '0);
   end

   assign bus.busA        = g_read[0].readOut;
   assign bus.busB        = g_read[1].readOut;
   assign bus.wr_conflict = wrConflictReg;
endmodule

// File: tb/tb_reg_file_mp.sv
// Runs four configurations side by side (default, no forwarding, zero r0, registered reads)
// from one directed stimulus stream; expectations go through a scoreboard queue.
module tb_reg_file_mp;
   logic        clk;
   logic        rst_n;
   logic        WE;
   logic        WE2;
   logic [2:0]  RW;
   logic [2:0]  RW2;
   logic [2:0]  RA;
   logic [2:0]  RB;
   logic [15:0] busW;
   logic [15:0] busW2;
   logic [15:0] busAArr [4];
   logic [15:0] busBArr [4];
   logic        wrcArr  [4];

   int errors = 0;
   int checks = 0;

   // cfg0 default, cfg1 BYPASS=0, cfg2 ZERO_R0=1, cfg3 READ_REG=1
   localparam logic [3:0] CFG_Z   = 4'b0100;
   localparam logic [3:0] CFG_BYP = 4'b1101;
   localparam logic [3:0] CFG_RR  = 4'b1000;

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      reg_file_mp_if #(.DW(16), .AW(3)) bus ();
      assign bus.WE    = WE;
      assign bus.RW    = RW;
      assign bus.busW  = busW;
      assign bus.WE2   = WE2;
      assign bus.RW2   = RW2;
      assign bus.busW2 = busW2;
      assign bus.RA    = RA;
      assign bus.RB    = RB;
      assign busAArr[gi] = bus.busA;
      assign busBArr[gi] = bus.busB;
      assign wrcArr[gi]  = bus.wr_conflict;

      reg_file_mp #(
         .DW(16), .AW(3),
         .ZERO_R0(int'(CFG_Z[gi])),
         .BYPASS(int'(CFG_BYP[gi])),
         .READ_REG(int'(CFG_RR[gi]))
      ) dut (
         .clk(clk),
         .rst_n(rst_n),
         .bus(bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          cfg;
      int          sel;
      logic [15:0] val;
   } exp_t;

   exp_t sb [$];

   task automatic expectVal(input string tag, input int cfg, input int sel, input logic [15:0] val);
      exp_t e;
      e.tag = tag; e.cfg = cfg; e.sel = sel; e.val = val;
      sb.push_back(e);
   endtask

   task automatic expectAll(input string tag, input int sel, input logic [15:0] val);
      for (int c = 0; c < 4; c++) expectVal(tag, c, sel, val);
   endtask

   // sel: 0 busA, 1 busB, 2 wr_conflict
   task automatic drain();
      exp_t        e;
      logic [15:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            0:       obs = busAArr[e.cfg];
            1:       obs = busBArr[e.cfg];
            default: obs = {15'b0, wrcArr[e.cfg]};
         endcase
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s cfg%0d sel%0d: observed %h expected %h", e.tag, e.cfg, e.sel, obs, e.val);
         end
         $display("check %s cfg%0d sel%0d obs=%h exp=%h", e.tag, e.cfg, e.sel, obs, e.val);
      end
   endtask

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      WE = 0; WE2 = 0; RW = 0; RW2 = 0; RA = 0; RB = 0; busW = 0; busW2 = 0;
      stepEdge();
      stepEdge();
      expectAll("rst_busA", 0, 16'h0000);
      expectAll("rst_wrc", 2, 16'h0000);
      drain();
      #2 rst_n = 1'b1;

      // Reset sweep
      for (int a = 0; a < 8; a++) begin
         RA = 3'(a); RB = 3'(a);
         stepEdge();
         expectAll("sweep_busA", 0, 16'h0000);
         expectAll("sweep_wrc", 2, 16'h0000);
         drain();
      end

      // Single-port writes, enable gating
      WE = 1; RW = 0; busW = 16'hff00; RA = 0; RB = 1;
      #1;
      expectVal("byp_r0", 0, 0, 16'hff00);
      expectVal("nobyp_r0", 1, 0, 16'h0000);
      expectVal("zero_r0", 2, 0, 16'h0000);
      drain();
      stepEdge();
      expectVal("e1_busA", 0, 0, 16'hff00);
      expectVal("e1_busA", 1, 0, 16'hff00);
      expectVal("e1_busA", 2, 0, 16'h0000);
      expectVal("e1_busA", 3, 0, 16'hff00);
      expectAll("e1_busB", 1, 16'h0000);
      drain();
      WE = 0; RW = 1; busW = 16'h00ff;
      stepEdge();
      expectAll("e2_busB", 1, 16'h0000);
      drain();
      WE = 1;
      #1;
      expectVal("e3pre_busB", 0, 1, 16'h00ff);
      expectVal("e3pre_busB", 1, 1, 16'h0000);
      drain();
      stepEdge();
      expectAll("e3_busB", 1, 16'h00ff);
      drain();

      // Same-address dual write: port 1 wins, one-cycle conflict pulse
      WE = 1; WE2 = 1; RW = 5; RW2 = 5; busW = 16'h1111; busW2 = 16'h2222; RA = 5;
      #1;
      expectVal("conf_byp", 0, 0, 16'h2222);
      expectVal("conf_nobyp", 1, 0, 16'h0000);
      drain();
      stepEdge();
      expectAll("conf_wrc", 2, 16'h0001);
      expectAll("conf_r5", 0, 16'h2222);
      drain();
      RW2 = 6; RB = 6;
      #1;
      expectVal("dual_byp_a", 0, 0, 16'h1111);
      expectVal("dual_byp_b", 0, 1, 16'h2222);
      drain();
      stepEdge();
      expectAll("dual_wrc", 2, 16'h0000);
      expectAll("dual_r5", 0, 16'h1111);
      expectAll("dual_r6", 1, 16'h2222);
      drain();

      // Dual write to address 0: conflict except where r0 is hard-wired
      RW = 0; RW2 = 0; busW = 16'hffff; busW2 = 16'heeee; RA = 0; RB = 5;
      #1;
      expectVal("z_pre", 2, 0, 16'h0000);
      expectVal("z_pre", 0, 0, 16'heeee);
      expectVal("z_pre", 1, 0, 16'hff00);
      drain();
      stepEdge();
      expectVal("z_wrc", 2, 2, 16'h0000);
      expectVal("z_wrc", 0, 2, 16'h0001);
      expectVal("z_wrc", 3, 2, 16'h0001);
      expectVal("z_post", 2, 0, 16'h0000);
      expectVal("z_post", 0, 0, 16'heeee);
      expectVal("z_post", 3, 0, 16'heeee);
      drain();

      // Forwarding vs. pre-edge read, registered read latency
      WE2 = 0; WE = 1; RW = 3; busW = 16'habcd; RA = 3;
      #1;
      expectVal("fw_byp", 0, 0, 16'habcd);
      expectVal("fw_nobyp", 1, 0, 16'h0000);
      expectVal("fw_rr_old", 3, 0, 16'heeee);
      drain();
      stepEdge();
      expectAll("fw_wrc", 2, 16'h0000);
      expectAll("fw_post", 0, 16'habcd);
      drain();

      // Reset pulse between edges while a write is pending
      RW = 7; busW = 16'hbeef; RA = 7; RB = 3;
      stepEdge();
      expectAll("r7_beef", 0, 16'hbeef);
      drain();
      busW = 16'h1234;
      #1 rst_n = 1'b0;
      #1;
      expectAll("midrst_busA", 0, 16'h0000);
      expectAll("midrst_wrc", 2, 16'h0000);
      drain();
      #2 rst_n = 1'b1;
      #1 WE = 0;
      #1;
      expectAll("rel_busA", 0, 16'h0000);
      drain();
      stepEdge();
      expectAll("rel_r7", 0, 16'h0000);
      expectAll("rel_r3", 1, 16'h0000);
      drain();

      // First write after release lands on the first edge
      WE = 1; RW = 2; busW = 16'h5a5a; RA = 2;
      stepEdge();
      WE = 0;
      #1;
      expectAll("first_wr", 0, 16'h5a5a);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
